// File: rtl/harvos_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package harvos_pkg;

    localparam int unsigned ILEN_BYTES = 4;

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_prefetch_queue.sv
// Circular instruction queue of fetch entries with flush and occupancy count.
module ifetch_queue
    import harvos_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer/count update; flush overrides any push or pop in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential PC generation, single outstanding
// icache request, redirect/FENCE.I kill handling and a decode-side queue.
module ifetch_prefetch
    import harvos_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fence_i,
    output logic        cache_req,
    output logic [31:0] cache_addr,
    input  logic [31:0] cache_rdata,
    input  logic        cache_rvalid,
    input  logic        cache_fault,
    output logic        cache_flush,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    output logic        fetch_busy
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             drop_q, drop_d;
    logic             halted_q, halted_d;
    logic             redirect, resp, issue, enq;
    fetch_entry_t     enq_entry, head;
    logic [CNT_W-1:0] q_count;

    assign redirect = redirect_valid | fence_i;
    assign resp     = cache_rvalid | cache_fault;

    // Next-state: redirect wins; otherwise IDLE issues, WAIT retires the response.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        halted_d  = halted_q;
        issue     = 1'b0;
        enq       = 1'b0;
        enq_entry = '{data: cache_rdata, pc: pc_q, fault: cache_fault};
        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            halted_d = 1'b0;
            if (state_q == F_WAIT) begin
                if (resp) begin
                    state_d = F_IDLE;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = 1'b1;
                end
            end
        end else begin
            case (state_q)
                F_IDLE: begin
                    // Empty slot in IDLE doubles as the reservation for this request.
                    if (!halted_q && (q_count < CNT_W'(QDEPTH))) begin
                        issue   = 1'b1;
                        state_d = F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (resp) begin
                        state_d = F_IDLE;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            enq = 1'b1;
                            if (cache_fault) begin
                                halted_d = 1'b1;
                            end else begin
                                pc_d = pc_q + 32'(ILEN_BYTES);
                            end
                        end
                    end
                end
                default: state_d = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= F_IDLE;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            halted_q <= halted_d;
        end
    end

    ifetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (enq),
        .push_entry (enq_entry),
        .pop        (instr_valid & instr_ready),
        .head       (head),
        .count      (q_count)
    );

    // Reset gating keeps the combinational request/flush quiet while rst_n is low.
    assign cache_req   = issue & rst_n;
    assign cache_addr  = cache_req ? pc_q : 32'h0;
    assign cache_flush = fence_i & rst_n;
    assign fetch_busy  = (state_q == F_WAIT) | drop_q;

    assign instr_valid = (q_count != '0);
    assign instr_data  = instr_valid ? head.data : 32'h0;
    assign instr_pc    = instr_valid ? head.pc : 32'h0;
    assign instr_fault = instr_valid & head.fault;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: directed scenarios plus random traffic
// against a queue-based reference model; a second instance covers PC wrap.
module tb_ifetch_prefetch;
    import harvos_pkg::*;

    localparam int unsigned QDEPTH  = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid, fence_i, instr_ready;
    logic [31:0] redirect_pc;
    logic        cache_req, cache_rvalid, cache_fault, cache_flush;
    logic [31:0] cache_addr, cache_rdata;
    logic        instr_valid, instr_fault, fetch_busy;
    logic [31:0] instr_data, instr_pc;
    logic        w_cache_req, w_cache_flush, w_instr_valid, w_instr_fault, w_fetch_busy, w_rvalid;
    logic [31:0] w_cache_addr, w_instr_data, w_instr_pc, w_rdata;

    always #5 clk = ~clk;

    ifetch_prefetch #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fence_i(fence_i), .cache_req(cache_req), .cache_addr(cache_addr),
        .cache_rdata(cache_rdata), .cache_rvalid(cache_rvalid), .cache_fault(cache_fault),
        .cache_flush(cache_flush), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .instr_fault(instr_fault),
        .fetch_busy(fetch_busy)
    );

    ifetch_prefetch #(.RESET_PC(WRAP_PC), .QDEPTH(QDEPTH)) u_wrap (
        .clk(clk), .rst_n(rst_n), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .fence_i(1'b0), .cache_req(w_cache_req), .cache_addr(w_cache_addr),
        .cache_rdata(w_rdata), .cache_rvalid(w_rvalid), .cache_fault(1'b0),
        .cache_flush(w_cache_flush), .instr_valid(w_instr_valid), .instr_ready(1'b1),
        .instr_data(w_instr_data), .instr_pc(w_instr_pc), .instr_fault(w_instr_fault),
        .fetch_busy(w_fetch_busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_out, m_drop, m_halt;
    bit          rsp_pend, rsp_flt, w_pend, fault_en, rnd_fault, found;
    int          rsp_due, w_due, lat_lo, lat_hi, first_valid_cyc, n, d0, k;
    logic [31:0] rsp_addr, w_addr, fault_addr;
    logic [31:0] req_log[$];
    logic [31:0] w_log[$];
    int          req_cyc[$];
    ent_t        deq_log[$];
    ent_t        w_deq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0;
        m_out = 0; m_drop = 0; m_halt = 0;
        rsp_pend = 0; w_pend = 0;
        req_log.delete(); req_cyc.delete(); deq_log.delete();
        w_log.delete(); w_deq.delete();
        first_valid_cyc = -1;
    endtask

    task automatic chk_zero(input string sfx);
        chk({"cache_req_", sfx}, 32'(cache_req), 0);
        chk({"cache_addr_", sfx}, cache_addr, 0);
        chk({"cache_flush_", sfx}, 32'(cache_flush), 0);
        chk({"instr_valid_", sfx}, 32'(instr_valid), 0);
        chk({"instr_data_", sfx}, instr_data, 0);
        chk({"instr_pc_", sfx}, instr_pc, 0);
        chk({"instr_fault_", sfx}, 32'(instr_fault), 0);
        chk({"fetch_busy_", sfx}, 32'(fetch_busy), 0);
        chk({"w_cache_req_", sfx}, 32'(w_cache_req), 0);
        chk({"w_cache_addr_", sfx}, w_cache_addr, 0);
        chk({"w_instr_valid_", sfx}, 32'(w_instr_valid), 0);
        chk({"w_fetch_busy_", sfx}, 32'(w_fetch_busy), 0);
    endtask

    // One clock cycle: icache responders drive, outputs are checked against
    // the model, the model advances, then time moves to the next posedge+1.
    task automatic cycle();
        bit   redir, ereq, eval, resp, pop;
        ent_t h;
        cache_rvalid = 0; cache_fault = 0; cache_rdata = '0;
        if (rsp_pend && cyc >= rsp_due) begin
            rsp_pend = 0;
            cache_rdata = rsp_addr ^ 32'hA5A5_0000;
            if (rsp_flt) begin
                cache_fault = 1;
                cache_rvalid = 1'($urandom_range(0, 1));
            end else begin
                cache_rvalid = 1;
            end
        end
        w_rvalid = 0; w_rdata = '0;
        if (w_pend && cyc >= w_due) begin
            w_pend = 0; w_rvalid = 1; w_rdata = w_addr ^ 32'hA5A5_0000;
        end
        #1;
        redir = redirect_valid | fence_i;
        eval  = (mq.size() != 0);
        ereq  = !redir && !m_out && !m_halt && (mq.size() < QDEPTH);
        chk("cache_req", 32'(cache_req), 32'(ereq));
        if (ereq) chk("cache_addr", cache_addr, m_pc);
        chk("cache_flush", 32'(cache_flush), 32'(fence_i));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_out));
        chk("instr_valid", 32'(instr_valid), 32'(eval));
        if (eval) begin
            h = mq[0];
            chk("instr_pc", instr_pc, h.pc);
            chk("instr_data", instr_data, h.data);
            chk("instr_fault", 32'(instr_fault), 32'(h.fault));
        end
        if (cache_req) begin
            rsp_pend = 1;
            rsp_addr = cache_addr;
            rsp_due  = cyc + int'($urandom_range(lat_hi, lat_lo));
            rsp_flt  = (fault_en && cache_addr == fault_addr) ||
                       (rnd_fault && $urandom_range(0, 15) == 0);
            req_log.push_back(cache_addr);
            req_cyc.push_back(cyc);
        end
        if (instr_valid && instr_ready) begin
            deq_log.push_back('{data: instr_data, pc: instr_pc, fault: instr_fault});
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (w_cache_req) begin
            w_pend = 1; w_due = cyc + 2; w_addr = w_cache_addr;
            w_log.push_back(w_cache_addr);
        end
        if (w_instr_valid) w_deq.push_back('{data: w_instr_data, pc: w_instr_pc, fault: w_instr_fault});
        resp = cache_rvalid | cache_fault;
        pop  = eval && instr_ready;
        if (redir) begin
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            m_halt = 0;
            if (m_out) begin
                if (resp) begin m_out = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (ereq) begin
                m_out = 1;
            end else if (m_out && resp) begin
                m_out = 0;
                if (m_drop) begin
                    m_drop = 0;
                end else begin
                    mq.push_back('{data: cache_rdata, pc: m_pc, fault: cache_fault});
                    if (cache_fault) m_halt = 1;
                    else m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic redirect_cycle(input logic [31:0] pc, input bit fence);
        redirect_pc = pc;
        redirect_valid = !fence;
        fence_i = fence;
        cycle();
        redirect_valid = 0;
        fence_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        redirect_valid = 0; fence_i = 0; redirect_pc = '0; instr_ready = 0;
        cache_rvalid = 0; cache_fault = 0; cache_rdata = '0; w_rvalid = 0; w_rdata = '0;
        fault_en = 0; fault_addr = '0; rnd_fault = 0; lat_lo = 2; lat_hi = 2;
        model_reset();
        @(posedge clk); #1;
        chk_zero("rst");
        rst_n = 1;

        // Sequential fetch, latency and wrap instance
        instr_ready = 1;
        repeat (16) cycle();
        chk("seq_addr0", req_log[0], 32'h0);
        chk("seq_addr1", req_log[1], 32'h4);
        chk("seq_addr2", req_log[2], 32'h8);
        chk("seq_addr3", req_log[3], 32'hC);
        chk("seq_pc4", deq_log[1].pc, 32'h4);
        chk("seq_data4", deq_log[1].data, 32'hA5A5_0004);
        chk("latency", 32'(first_valid_cyc - req_cyc[0]), 32'd3);
        chk("wrap_addr0", w_log[0], WRAP_PC);
        chk("wrap_addr1", w_log[1], 32'h0);
        chk("wrap_pc0", w_deq[0].pc, WRAP_PC);
        chk("wrap_data0", w_deq[0].data, 32'h5A5A_FFFC);

        // Backpressure fills exactly QDEPTH entries
        instr_ready = 0;
        redirect_cycle(32'h100, 0);
        n = req_log.size();
        repeat (40) cycle();
        chk("full_reqs", 32'(req_log.size() - n), QDEPTH);
        chk("full_head", instr_pc, 32'h100);
        instr_ready = 1;
        cycle();
        instr_ready = 0;
        n = req_log.size();
        repeat (20) cycle();
        chk("one_more_cnt", 32'(req_log.size() - n), 32'd1);
        chk("one_more_addr", req_log[$], 32'h110);

        // Redirect while waiting on address 8
        instr_ready = 1; lat_lo = 3; lat_hi = 3;
        redirect_cycle(32'h0, 0);
        n = req_log.size();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (req_log.size() > n && req_log[$] == 32'h8) begin found = 1; break; end
        end
        chk("found_wait8", 32'(found), 1);
        redirect_cycle(32'h0000_1003, 0);
        d0 = deq_log.size();
        n = req_log.size();
        k = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (req_log.size() > n) begin k = i; break; end
        end
        chk("drop_wait", 32'(k), 32'd2);
        chk("redir_addr", req_log[$], 32'h0000_1000);
        repeat (8) cycle();
        chk("redir_first_pc", deq_log[d0].pc, 32'h0000_1000);

        // Redirect coincident with a response
        lat_lo = 2; lat_hi = 2;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_pend && rsp_due == cyc) begin found = 1; break; end
            cycle();
        end
        chk("found_same", 32'(found), 1);
        redirect_cycle(32'h0000_2000, 0);
        d0 = deq_log.size();
        n = req_log.size();
        cycle();
        chk("same_next_cnt", 32'(req_log.size() - n), 32'd1);
        chk("same_next_addr", req_log[$], 32'h0000_2000);
        repeat (6) cycle();
        chk("same_first_pc", deq_log[d0].pc, 32'h0000_2000);

        // Fault halts fetch; FENCE.I flushes and resumes
        fault_en = 1; fault_addr = 32'h10;
        redirect_cycle(32'h8, 0);
        repeat (30) cycle();
        chk("fault_last_req", req_log[$], 32'h10);
        n = req_log.size();
        repeat (10) cycle();
        chk("halt_noreq", 32'(req_log.size() - n), 32'd0);
        chk("fault_entry_pc", deq_log[$].pc, 32'h10);
        chk("fault_entry_flag", 32'(deq_log[$].fault), 32'd1);
        fault_en = 0;
        redirect_cycle(32'h20, 1);
        cycle();
        chk("fence_resume", req_log[$], 32'h20);

        // Random traffic
        rnd_fault = 1; lat_lo = 2; lat_hi = 5;
        for (int i = 0; i < 600; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            k = int'($urandom_range(0, 99));
            if (k < 3) redirect_cycle($urandom(), 0);
            else if (k < 4) redirect_cycle($urandom(), 1);
            else cycle();
        end

        // Asynchronous reset in the middle of a WAIT
        rnd_fault = 0; lat_lo = 2; lat_hi = 2; instr_ready = 1;
        redirect_cycle(32'h40, 0);
        for (int i = 0; i < 10 && !m_out; i++) cycle();
        chk("busy_before_rst", 32'(fetch_busy), 32'd1);
        #1;
        rst_n = 0;
        cache_rvalid = 0; cache_fault = 0; cache_rdata = '0; w_rvalid = 0; w_rdata = '0;
        #1;
        chk_zero("rst_mid");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (8) cycle();
        chk("restart_main", req_log[0], 32'h0);
        chk("restart_wrap0", w_log[0], WRAP_PC);
        chk("restart_wrap1", w_log[1], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- CPU instruction-fetch front end; sits directly upstream of the icache CPU port.
- Generates sequential word-aligned fetch PCs and keeps at most one icache request outstanding.
- Buffers returned words in a small queue that feeds decode.
- Handles branch/trap redirects and FENCE.I by killing in-flight responses and flushing the queue.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 4, instruction queue entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- redirect_valid  in  1  one-cycle redirect request (branch/jump/trap)
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- fence_i  in  1  one-cycle FENCE.I; redirects to redirect_pc and flushes the cache
- cache_req  out  1  one-cycle fetch request pulse to icache
- cache_addr  out  32  fetch address, word-aligned, valid with cache_req
- cache_rdata  in  32  icache read data
- cache_rvalid  in  1  icache response valid
- cache_fault  in  1  icache fault (with or without rvalid)
- cache_flush  out  1  flush-all pulse to icache
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr_data  out  32  head instruction word
- instr_pc  out  32  head PC
- instr_fault  out  1  head is a fetch fault marker
- fetch_busy  out  1  request outstanding or kill pending

Behaviour:
- Reset (async):
  - pc_q = RESET_PC; FSM in IDLE; queue empty.
  - drop_q = 0, halted_q = 0.
  - All outputs are 0 during reset.
- FSM IDLE:
  - Issue cache_req = 1 with cache_addr = pc_q when all of: not halted_q; (count + 1) <= QDEPTH; no redirect_valid/fence_i this cycle.
  - On issue, go to WAIT.
  - cache_req is never high two cycles in a row.
- FSM WAIT:
  - A response is cache_rvalid | cache_fault.
  - Response with drop_q = 0:
    - Enqueue {data = cache_rdata, pc = pc_q, fault = cache_fault}.
    - If no fault, pc_q <= pc_q + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
    - If fault, halted_q <= 1 and pc_q is held.
    - Go to IDLE.
  - Response with drop_q = 1: discard it, clear drop_q, go to IDLE.
- Space reservation: the queue slot is reserved at issue, so an enqueue can never overflow.
- Redirect (redirect_valid | fence_i), highest priority:
  - Queue flushed same cycle; instr_valid = 0 the next cycle.
  - pc_q <= {redirect_pc[31:2], 2'b00}; halted_q <= 0.
  - If in WAIT and no response this cycle, drop_q <= 1.
  - If a response arrives the same cycle, drop it and go to IDLE.
  - Redirect while drop_q is already 1: update pc_q only.
  - No cache_req in the redirect cycle; the earliest new request is the next cycle.
- fence_i additionally drives cache_flush = 1 for exactly that cycle.
- Queue:
  - Circular buffer with rd/wr pointers of log2(QDEPTH) bits plus count of log2(QDEPTH)+1 bits.
  - Head is driven combinationally from storage.
  - Dequeue when instr_valid & instr_ready.
  - Simultaneous enqueue and dequeue: count unchanged.
  - Full: no new issue; an existing reservation still completes.
  - Empty: instr_valid = 0; instr_data, instr_pc and instr_fault are don't-care.
- Fault entry: after a fault entry is enqueued, no further fetch until a redirect.
- Latency: issue at cycle t gives the earliest instr_valid at t+3 (the icache takes at least 2 cycles; enqueue is registered).
- fetch_busy = (state == WAIT) | drop_q.

Decomposition:
- Shared package (harvos_pkg):
  - fetch_state_e {F_IDLE, F_WAIT}
  - fetch_entry_t {data[31:0], pc[31:0], fault}
  - ILEN_BYTES = 4
- One sub-module: ifetch_queue (parameterised FIFO of fetch_entry_t with flush, count output).
  - The FSM and PC logic stay in ifetch_prefetch.

Test Plan:
- Reset release, icache model returns data = addr ^ 32'hA5A5_0000 after 2 cycles, instr_ready = 1.
  - Expect cache_addr sequence 0, 4, 8, 12.
  - Expect instr_pc matching, instr_data = 32'hA5A5_0004 at pc 4.
- instr_ready = 0 with QDEPTH = 4.
  - Exactly 4 requests issued, then cache_req stays 0.
  - Raising instr_ready for 1 cycle allows exactly one new request.
- redirect_valid with redirect_pc = 32'h0000_1003 while in WAIT for addr 8.
  - Response for 8 dropped, queue empties.
  - Next cache_addr = 32'h0000_1000; fetch_busy high until the dropped response returns.
- redirect_valid in the same cycle as cache_rvalid.
  - Response not enqueued; next request to the redirect target one cycle later.
- cache_fault at addr 32'h0000_0010.
  - Entry has instr_fault = 1, instr_pc = 32'h10; no further cache_req.
  - fence_i with redirect_pc = 32'h20 gives a one-cycle cache_flush and fetch resumes at 32'h20.
- RESET_PC = 32'hFFFF_FFFC.
  - Fetch order FFFF_FFFC then 0000_0000 (wrap).
  - Assert rst_n low mid-WAIT: all outputs 0 immediately, restart from RESET_PC.
